// File: rtl/rob_commit_if.sv
// Issue, CDB and commit signals of the in-order reorder buffer bundled as one port.
// The ROB side uses the slave modport; the issue stage / bench uses master.
interface rob_commit_if #(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 64
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              issue_valid;
    logic [TAG_W-1:0]  issue_tag;
    logic              issue_nodest;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic [TAG_W-1:0]  rob_id;
    logic [DATA_W-1:0] rob_data;
    logic              rob_full;
    logic              rob_empty;
    logic [CNT_W-1:0]  rob_count;

    modport master (
        output issue_valid, issue_tag, issue_nodest,
        output cdb_valid, cdb_tag, cdb_data,
        input  rob_id, rob_data, rob_full, rob_empty, rob_count
    );

    modport slave (
        input  issue_valid, issue_tag, issue_nodest,
        input  cdb_valid, cdb_tag, cdb_data,
        output rob_id, rob_data, rob_full, rob_empty, rob_count
    );
endinterface

// File: rtl/rob_commit.sv
// In-order reorder buffer: allocates at issue, captures CDB results out of order, retires in order.
// Optional feature macro ROB_BYPASS_EN lets a CDB result for the head entry retire on the same edge.
module rob_commit #(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 64
) (
    input logic        clk,
    input logic        rst,
    rob_commit_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]  ent_valid;
    logic [DEPTH-1:0]  ent_ready;
    logic [DEPTH-1:0]  ent_nodest;
    logic [TAG_W-1:0]  ent_tag  [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    logic [TAG_W-1:0]  rob_id_q;
    logic [DATA_W-1:0] rob_data_q;

    logic              full;
    logic              issue_fire;
    logic              cap_hit;
    logic [PTR_W-1:0]  cap_idx;
    logic              head_done;
    logic              bypass;
    logic              commit_fire;
    logic              capture_write;

    assign full       = (count == CNT_W'(DEPTH));
    assign issue_fire = bus.issue_valid && (bus.issue_tag != '0) && !full;

    // Tags are reused by the RS, so scan outward from head and take the oldest waiting match.
    // The slot being allocated this cycle is still invalid, so it can never match.
    always_comb begin
        logic [PTR_W-1:0] idx;
        cap_hit = 1'b0;
        cap_idx = '0;
        idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (!cap_hit && bus.cdb_valid && (bus.cdb_tag != '0) &&
                ent_valid[idx] && !ent_ready[idx] && (ent_tag[idx] == bus.cdb_tag)) begin
                cap_hit = 1'b1;
                cap_idx = idx;
            end
        end
    end

    assign head_done = ent_valid[head] && ent_ready[head];

`ifdef ROB_BYPASS_EN
    assign bypass = ent_valid[head] && !ent_ready[head] && cap_hit && (cap_idx == head);
`else
    assign bypass = 1'b0;
`endif

    assign commit_fire   = head_done || bypass;
    assign capture_write = cap_hit && !bypass;

    // Issue only targets the tail when not full and commit only frees the head when not
    // empty, so the two never land on the same slot in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_valid <= '0;
            ent_ready <= '0;
        end else begin
            if (commit_fire) begin
                ent_valid[head] <= 1'b0;
            end
            if (capture_write) begin
                ent_ready[cap_idx] <= 1'b1;
            end
            if (issue_fire) begin
                ent_valid[tail] <= 1'b1;
                ent_ready[tail] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue_fire) begin
            ent_tag[tail]    <= bus.issue_tag;
            ent_nodest[tail] <= bus.issue_nodest;
        end
        if (capture_write) begin
            ent_data[cap_idx] <= bus.cdb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(commit_fire);
            tail  <= tail + PTR_W'(issue_fire);
            count <= count + CNT_W'(issue_fire) - CNT_W'(commit_fire);
        end
    end

    // rob_id is a one-cycle pulse per retirement; rob_data keeps the last retired value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rob_id_q   <= '0;
            rob_data_q <= '0;
        end else if (commit_fire) begin
            rob_id_q   <= ent_nodest[head] ? '0 : ent_tag[head];
            rob_data_q <= bypass ? bus.cdb_data : ent_data[head];
        end else begin
            rob_id_q <= '0;
        end
    end

    assign bus.rob_id    = rob_id_q;
    assign bus.rob_data  = rob_data_q;
    assign bus.rob_full  = full;
    assign bus.rob_empty = (count == '0);
    assign bus.rob_count = count;
endmodule

// File: tb/tb_rob_commit.sv
// Scoreboard bench for rob_commit: a queue-based ROB model predicts retirements,
// and an independent monitor matches every nonzero rob_id against the predictions.
module tb_rob_commit;
    localparam int DEPTH  = 8;
    localparam int TAG_W  = 4;
    localparam int DATA_W = 64;

    typedef struct {
        logic [TAG_W-1:0]  tag;
        bit                nodest;
        bit                ready;
        logic [DATA_W-1:0] data;
    } ent_t;

    typedef struct {
        logic [TAG_W-1:0]  id;
        logic [DATA_W-1:0] data;
    } commit_t;

    logic clk = 1'b0;
    logic rst;

    ent_t              model_q[$];
    commit_t           exp_q[$];
    logic [DATA_W-1:0] model_data;
    int                checks = 0;
    int                errors = 0;

    rob_commit_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

    rob_commit #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference ROB: a queue in program order; everything decided from the pre-edge state.
    task automatic modelStep(input bit iv, input logic [TAG_W-1:0] itag, input bit ind,
                             input bit cv, input logic [TAG_W-1:0] ctag, input logic [DATA_W-1:0] cdata);
        bit      was_full;
        int      cap;
        bit      do_commit;
        commit_t c;
        ent_t    e;
        was_full  = (model_q.size() == DEPTH);
        cap       = -1;
        do_commit = 1'b0;
        c.id      = '0;
        c.data    = '0;
        if (cv && ctag != '0) begin
            for (int i = 0; i < model_q.size(); i++) begin
                if (cap < 0 && !model_q[i].ready && model_q[i].tag == ctag) cap = i;
            end
        end
        if (model_q.size() > 0 && model_q[0].ready) begin
            do_commit = 1'b1;
            c.data    = model_q[0].data;
        end
`ifdef ROB_BYPASS_EN
        else if (cap == 0) begin
            do_commit = 1'b1;
            c.data    = cdata;
            cap       = -1;
        end
`endif
        if (cap >= 0) begin
            model_q[cap].ready = 1'b1;
            model_q[cap].data  = cdata;
        end
        if (do_commit) begin
            c.id       = model_q[0].nodest ? '0 : model_q[0].tag;
            model_data = c.data;
            if (c.id != '0) exp_q.push_back(c);
            void'(model_q.pop_front());
        end
        if (iv && itag != '0 && !was_full) begin
            e.tag    = itag;
            e.nodest = ind;
            e.ready  = 1'b0;
            e.data   = '0;
            model_q.push_back(e);
        end
    endtask

    task automatic applyStimulus(input bit iv, input logic [TAG_W-1:0] itag, input bit ind,
                                 input bit cv, input logic [TAG_W-1:0] ctag, input logic [DATA_W-1:0] cdata);
        @(negedge clk);
        bus.issue_valid  = iv;
        bus.issue_tag    = itag;
        bus.issue_nodest = ind;
        bus.cdb_valid    = cv;
        bus.cdb_tag      = ctag;
        bus.cdb_data     = cdata;
        modelStep(iv, itag, ind, cv, ctag, cdata);
        @(posedge clk);
        #1;
        checkOutput("rob_count", 64'(bus.rob_count), 64'(model_q.size()));
        checkOutput("rob_full",  64'(bus.rob_full),  64'(model_q.size() == DEPTH));
        checkOutput("rob_empty", 64'(bus.rob_empty), 64'(model_q.size() == 0));
        checkOutput("rob_data",  bus.rob_data, model_data);
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic cdbOldest(input bit iv, input logic [TAG_W-1:0] itag);
        int idx;
        idx = -1;
        for (int i = 0; i < model_q.size(); i++) begin
            if (idx < 0 && !model_q[i].ready) idx = i;
        end
        if (idx >= 0) applyStimulus(iv, itag, 1'b0, 1'b1, model_q[idx].tag, {$urandom, $urandom});
        else          applyStimulus(iv, itag, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic drain();
        for (int c = 0; c < 40 && model_q.size() > 0; c++) cdbOldest(1'b0, '0);
        idle();
        idle();
    endtask

    task automatic randomCycle();
        bit               iv;
        bit               ind;
        bit               cv;
        logic [TAG_W-1:0] itag;
        logic [TAG_W-1:0] ctag;
        int               pend[$];
        iv   = ($urandom_range(0, 99) < 60);
        itag = TAG_W'($urandom_range(0, 3));
        ind  = ($urandom_range(0, 3) == 0);
        cv   = ($urandom_range(0, 99) < 70);
        ctag = TAG_W'($urandom_range(0, 15));
        for (int i = 0; i < model_q.size(); i++) if (!model_q[i].ready) pend.push_back(i);
        if (pend.size() > 0 && $urandom_range(0, 99) < 80)
            ctag = model_q[pend[$urandom_range(0, pend.size() - 1)]].tag;
        applyStimulus(iv, itag, ind, cv, ctag, {$urandom, $urandom});
    endtask

    // Monitor: every nonzero rob_id must be the next predicted retirement.
    initial begin
        commit_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.rob_id !== '0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_commit: got rob_id 0x%0h, expected no commit at %0t",
                             bus.rob_id, $time);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("commit_id",   64'(bus.rob_id), 64'(e.id));
                    checkOutput("commit_data", bus.rob_data,    e.data);
                end
            end
        end
    end

    initial begin
        rst              = 1'b1;
        bus.issue_valid  = 1'b0;
        bus.issue_tag    = '0;
        bus.issue_nodest = 1'b0;
        bus.cdb_valid    = 1'b0;
        bus.cdb_tag      = '0;
        bus.cdb_data     = '0;
        model_data       = '0;
        #12;
        checkOutput("reset_count", 64'(bus.rob_count), 64'd0);
        checkOutput("reset_empty", 64'(bus.rob_empty), 64'd1);
        checkOutput("reset_full",  64'(bus.rob_full),  64'd0);
        checkOutput("reset_id",    64'(bus.rob_id),    64'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] in-order retirement");
        applyStimulus(1'b1, 4'd1, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b1, 4'd4, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b1, 4'd6, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 4'd6, 64'hA);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 4'd4, 64'hB);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 4'd1, 64'hC);
        idle(); idle(); idle(); idle();

        $display("[TB] full and stall");
        for (int t = 1; t <= 9; t++) applyStimulus(1'b1, TAG_W'(t), 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b1, 4'd10, 1'b0, 1'b1, 4'd1, 64'h11);
        applyStimulus(1'b1, 4'd11, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b1, 4'd12, 1'b0, 1'b0, '0, '0);
        drain();

        $display("[TB] tag reuse");
        applyStimulus(1'b1, 4'd1, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b1, 4'd1, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 4'd1, 64'h5);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 4'd1, 64'h7);
        idle(); idle(); idle();

        $display("[TB] nodest and bypass timing");
        applyStimulus(1'b1, 4'd9, 1'b1, 1'b0, '0, '0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 4'd9, 64'h99);
        idle(); idle();
        applyStimulus(1'b1, 4'd2, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 4'd2, 64'h3);
        idle(); idle();

        $display("[TB] wrap with simultaneous issue, capture and commit");
        for (int c = 0; c < 20; c++) cdbOldest(1'b1, TAG_W'((c % 15) + 1));
        drain();

        $display("[TB] randomized traffic");
        for (int c = 0; c < 400; c++) randomCycle();
        drain();

        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, 4'd2, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b1, 4'd3, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b1, 4'd5, 1'b0, 1'b0, '0, '0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midreset_count", 64'(bus.rob_count), 64'd0);
        checkOutput("midreset_empty", 64'(bus.rob_empty), 64'd1);
        checkOutput("midreset_full",  64'(bus.rob_full),  64'd0);
        checkOutput("midreset_id",    64'(bus.rob_id),    64'd0);
        model_q.delete();
        exp_q.delete();
        model_data = '0;
        @(negedge clk);
        bus.issue_valid = 1'b0;
        bus.cdb_valid   = 1'b0;
        rst = 1'b0;
        applyStimulus(1'b1, 4'd7, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 4'd7, 64'h77);
        idle(); idle(); idle();

        checkOutput("pending_commits", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
